dram_line_master: RTL and testbench



---
 rtl/dram_pkg.sv | 18 +
 rtl/dram_line_master.sv | 141 ++++++++++++++
 tb/tb_dram_line_master.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared command encodings, line geometry and state type for the DRAM line master
package dram_pkg;

    localparam logic DRAM_CMD_WRITE = 1'b0;
    localparam logic DRAM_CMD_READ  = 1'b1;

    // One line is one MIG BL8 burst on a 64-bit UI, seen here as four 32-bit words.
    localparam int LINE_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_CMD,
        READ_DATA,
        RESP
    } line_state_t;

endpackage

// File: rtl/dram_line_master.sv
// rtl/dram_line_master.sv - one-at-a-time 16-byte line transfer engine in front of the DRAM controller
module dram_line_master #(
    parameter int LINE_WORDS = 4
) (
    input  logic         clk_core,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [23:0]  req_addr,
    input  logic [127:0] req_wdata,
    input  logic [15:0]  req_wmask,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_rdata,
    output logic         resp_error,
    output logic         bmain_cvalid_dctl,
    input  logic         dctl_cready,
    output logic         bmain_cmd,
    output logic [25:0]  bmain_addr,
    output logic         bmain_wvalid_dctl,
    input  logic         dctl_wready,
    output logic         bmain_wlast,
    output logic [31:0]  bmain_wdata,
    output logic [3:0]   bmain_wmask,
    input  logic         dctl_rvalid,
    output logic         bmain_rready_dctl,
    input  logic         dctl_rlast,
    input  logic [31:0]  dctl_rdata,
    input  logic         dctl_error
);
    import dram_pkg::*;

    localparam logic [2:0] WORDS     = 3'(LINE_WORDS);
    localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

    line_state_t  state;
    line_state_t  state_nx;

    // Line buffer is shared: it sources write words and sinks read words.
    logic [23:0]  addr_q;
    logic         write_q;
    logic [127:0] line_q;
    logic [15:0]  mask_q;
    logic [2:0]   wcnt;
    logic [1:0]   rcnt;
    logic         cmd_done;
    logic         err_q;

    logic         req_hs;
    logic         cmd_hs;
    logic         w_hs;
    logic         r_hs;
    logic         resp_hs;
    logic         cmd_done_nx;
    logic [2:0]   wcnt_nx;

    assign req_ready         = (state == IDLE);
    assign bmain_cvalid_dctl = ((state == WRITE) && !cmd_done) || (state == READ_CMD);
    assign bmain_cmd         = (state == READ_CMD) ? DRAM_CMD_READ : DRAM_CMD_WRITE;
    assign bmain_addr        = {addr_q, 2'b00};
    assign bmain_wvalid_dctl = (state == WRITE) && (wcnt < WORDS);
    assign bmain_wlast       = bmain_wvalid_dctl && (wcnt == WORDS - 3'd1);
    assign bmain_wdata       = line_q[{wcnt[1:0], 5'd0} +: 32];
    assign bmain_wmask       = mask_q[{wcnt[1:0], 2'd0} +: 4];
    assign bmain_rready_dctl = (state == READ_DATA);
    assign resp_valid        = (state == RESP);
    assign resp_rdata        = write_q ? '0 : line_q;
    assign resp_error        = resp_valid && err_q;

    assign req_hs      = req_valid && req_ready;
    assign cmd_hs      = bmain_cvalid_dctl && dctl_cready;
    assign w_hs        = bmain_wvalid_dctl && dctl_wready;
    assign r_hs        = bmain_rready_dctl && dctl_rvalid;
    assign resp_hs     = resp_valid && resp_ready;
    assign cmd_done_nx = cmd_done || cmd_hs;
    assign wcnt_nx     = wcnt + {2'b00, w_hs};

    // State register.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: a write finishes only once both the command and the last word have gone.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (req_hs) state_nx = req_write ? WRITE : READ_CMD;
            WRITE:     if (cmd_done_nx && (wcnt_nx == WORDS)) state_nx = RESP;
            READ_CMD:  if (cmd_hs) state_nx = READ_DATA;
            READ_DATA: if (r_hs && dctl_rlast) state_nx = RESP;
            RESP:      if (resp_hs) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Request latch, burst counters, read-word capture and sticky error flag.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            line_q   <= '0;
            mask_q   <= '0;
            wcnt     <= '0;
            rcnt     <= '0;
            cmd_done <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (req_hs) begin
                addr_q   <= req_addr;
                write_q  <= req_write;
                line_q   <= req_wdata;
                mask_q   <= req_wmask;
                wcnt     <= '0;
                rcnt     <= '0;
                cmd_done <= 1'b0;
                err_q    <= 1'b0;
            end
            if (state == WRITE) begin
                cmd_done <= cmd_done_nx;
                wcnt     <= wcnt_nx;
            end
            if (r_hs) begin
                line_q[{rcnt, 5'd0} +: 32] <= dctl_rdata;
                rcnt <= rcnt + 2'd1;
                // Burst length mismatch either way; an overlong burst keeps draining until rlast.
                if (dctl_rlast != (rcnt == LAST_WORD)) begin
                    err_q <= 1'b1;
                end
            end
            if ((state != IDLE) && dctl_error) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dram_line_master.sv
// tb/tb_dram_line_master.sv - directed self-checking bench for dram_line_master
module tb_dram_line_master;

    logic         clk_core = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [23:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_wmask;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_rdata;
    logic         resp_error;
    logic         bmain_cvalid_dctl;
    logic         dctl_cready;
    logic         bmain_cmd;
    logic [25:0]  bmain_addr;
    logic         bmain_wvalid_dctl;
    logic         dctl_wready;
    logic         bmain_wlast;
    logic [31:0]  bmain_wdata;
    logic [3:0]   bmain_wmask;
    logic         dctl_rvalid;
    logic         bmain_rready_dctl;
    logic         dctl_rlast;
    logic [31:0]  dctl_rdata;
    logic         dctl_error;

    int checks = 0;
    int errors = 0;

    always #5 clk_core = ~clk_core;

    dram_line_master #(.LINE_WORDS(4)) dut (
        .clk_core          (clk_core),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_wmask         (req_wmask),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_error        (resp_error),
        .bmain_cvalid_dctl (bmain_cvalid_dctl),
        .dctl_cready       (dctl_cready),
        .bmain_cmd         (bmain_cmd),
        .bmain_addr        (bmain_addr),
        .bmain_wvalid_dctl (bmain_wvalid_dctl),
        .dctl_wready       (dctl_wready),
        .bmain_wlast       (bmain_wlast),
        .bmain_wdata       (bmain_wdata),
        .bmain_wmask       (bmain_wmask),
        .dctl_rvalid       (dctl_rvalid),
        .bmain_rready_dctl (bmain_rready_dctl),
        .dctl_rlast        (dctl_rlast),
        .dctl_rdata        (dctl_rdata),
        .dctl_error        (dctl_error)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_core);
    endtask

    // Bus monitor: samples just before each rising edge, records handshakes, checks hold rules.
    logic [31:0] wq_data[$];
    logic [3:0]  wq_mask[$];
    logic        wq_last[$];
    int          cmd_hs_cnt = 0;
    logic        prev_wstall = 1'b0;
    logic        prev_cstall = 1'b0;
    logic [31:0] prev_wdata;
    logic [25:0] prev_addr;

    always @(negedge clk_core) begin
        #4;
        if (reset) begin
            prev_wstall = 1'b0;
            prev_cstall = 1'b0;
        end else begin
            if (prev_wstall) begin
                chk("w_hold_valid", bmain_wvalid_dctl, 1'b1);
                chk("w_hold_data", bmain_wdata, prev_wdata);
            end
            if (prev_cstall) begin
                chk("c_hold_valid", bmain_cvalid_dctl, 1'b1);
                chk("c_hold_addr", bmain_addr, prev_addr);
            end
            if (bmain_wvalid_dctl && dctl_wready) begin
                wq_data.push_back(bmain_wdata);
                wq_mask.push_back(bmain_wmask);
                wq_last.push_back(bmain_wlast);
            end
            if (bmain_cvalid_dctl && dctl_cready) cmd_hs_cnt++;
            prev_wstall = bmain_wvalid_dctl && !dctl_wready;
            prev_cstall = bmain_cvalid_dctl && !dctl_cready;
            prev_wdata  = bmain_wdata;
            prev_addr   = bmain_addr;
        end
    end

    task automatic write_best(input logic [23:0] a, input logic [127:0] d, input logic [15:0] m,
                              input string tg);
        chk({tg, "_req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
        dctl_cready = 1'b1; dctl_wready = 1'b1; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        chk({tg, "_cvalid"}, bmain_cvalid_dctl, 1'b1);
        chk({tg, "_addr"}, bmain_addr, {a, 2'b00});
        chk({tg, "_cmd"}, bmain_cmd, 1'b0);
        chk({tg, "_busy"}, req_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk({tg, "_wvalid"}, bmain_wvalid_dctl, 1'b1);
            chk({tg, "_wdata"}, bmain_wdata, d[32*i +: 32]);
            chk({tg, "_wmask"}, bmain_wmask, m[4*i +: 4]);
            chk({tg, "_wlast"}, bmain_wlast, (i == 3));
            if (i > 0) chk({tg, "_cmd_once"}, bmain_cvalid_dctl, 1'b0);
            tick();
        end
        chk({tg, "_resp_valid"}, resp_valid, 1'b1);
        chk({tg, "_resp_error"}, resp_error, 1'b0);
        chk({tg, "_resp_rdata"}, resp_rdata, 128'h0);
        chk({tg, "_wvalid_off"}, bmain_wvalid_dctl, 1'b0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tg, "_resp_done"}, resp_valid, 1'b0);
        chk({tg, "_idle"}, req_ready, 1'b1);
    endtask

    task automatic read_start(input logic [23:0] a, input string tg);
        chk({tg, "_req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; dctl_cready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tg, "_cvalid"}, bmain_cvalid_dctl, 1'b1);
        chk({tg, "_cmd"}, bmain_cmd, 1'b1);
        chk({tg, "_addr"}, bmain_addr, {a, 2'b00});
        chk({tg, "_no_rready"}, bmain_rready_dctl, 1'b0);
        tick();
        chk({tg, "_rready"}, bmain_rready_dctl, 1'b1);
        chk({tg, "_cvalid_off"}, bmain_cvalid_dctl, 1'b0);
    endtask

    task automatic send_beat(input logic [31:0] data, input logic last);
        dctl_rvalid = 1'b1; dctl_rdata = data; dctl_rlast = last;
        tick();
        dctl_rvalid = 1'b0; dctl_rlast = 1'b0; dctl_rdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        resp_ready = 1'b0; dctl_cready = 1'b1; dctl_wready = 1'b1;
        dctl_rvalid = 1'b0; dctl_rlast = 1'b0; dctl_rdata = '0; dctl_error = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_cvalid", bmain_cvalid_dctl, 1'b0);
        chk("rst_wvalid", bmain_wvalid_dctl, 1'b0);
        chk("rst_rready", bmain_rready_dctl, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_addr", bmain_addr, 26'h0);
        chk("rst_rdata", resp_rdata, 128'h0);
        reset = 1'b0;
        tick();

        // Best-case write.
        write_best(24'h00_0010, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                   16'hFFFF, "wr1");

        // Write with stalled command and toggling write-ready.
        wq_data.delete(); wq_mask.delete(); wq_last.delete(); cmd_hs_cnt = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 24'hABCDE;
        req_wdata = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
        req_wmask = 16'h0F3C;
        dctl_cready = 1'b0; dctl_wready = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 40 && !resp_valid; i++) begin
            dctl_cready = (i >= 6);
            dctl_wready = i[0];
            tick();
        end
        chk("wr2_resp_seen", resp_valid, 1'b1);
        chk("wr2_cmd_count", cmd_hs_cnt, 1);
        chk("wr2_beat_count", wq_data.size(), 4);
        if (wq_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("wr2_wdata", wq_data[i], 32'hDEAD0000 + i);
                chk("wr2_wmask", wq_mask[i], req_wmask[4*i +: 4]);
                chk("wr2_wlast", wq_last[i], (i == 3));
            end
        end
        chk("wr2_resp_error", resp_error, 1'b0);
        dctl_cready = 1'b1; dctl_wready = 1'b1;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Gapped read.
        read_start(24'h012345, "rd1");
        for (int i = 0; i < 4; i++) begin
            send_beat(32'hA0 + i, (i == 3));
            if (i < 3) begin
                chk("rd1_busy", req_ready, 1'b0);
                chk("rd1_no_resp", resp_valid, 1'b0);
                tick();
            end
        end
        chk("rd1_resp_valid", resp_valid, 1'b1);
        chk("rd1_rdata", resp_rdata, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("rd1_error", resp_error, 1'b0);
        chk("rd1_busy_resp", req_ready, 1'b0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Read with early rlast on the second word, then a normal write.
        read_start(24'h000001, "rd2");
        send_beat(32'hB0, 1'b0);
        send_beat(32'hB1, 1'b1);
        chk("rd2_resp_valid", resp_valid, 1'b1);
        chk("rd2_error", resp_error, 1'b1);
        chk("rd2_low_words", resp_rdata[63:0], {32'hB1, 32'hB0});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        write_best(24'h00_0020, {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555},
                   16'hF00F, "wr3");

        // Response back-pressure with a pending new request.
        read_start(24'h000002, "rd3");
        for (int i = 0; i < 4; i++) send_beat(32'hC0 + i, (i == 3));
        req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000003;
        for (int i = 0; i < 10; i++) begin
            chk("bp_resp_valid", resp_valid, 1'b1);
            chk("bp_rdata", resp_rdata, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_no_cmd", bmain_cvalid_dctl, 1'b0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp_released", resp_valid, 1'b0);
        chk("bp_idle", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("bp_next_cmd", bmain_cvalid_dctl, 1'b1);
        chk("bp_next_addr", bmain_addr, 26'hC);
        chk("bp_next_read", bmain_cmd, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) send_beat(32'hD0 + i, (i == 3));
        chk("rd4_rdata", resp_rdata, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        chk("rd4_error", resp_error, 1'b0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset in the middle of a read burst.
        read_start(24'h000004, "rd5");
        send_beat(32'hE0, 1'b0);
        send_beat(32'hE1, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_req_ready", req_ready, 1'b1);
        chk("mid_rst_cvalid", bmain_cvalid_dctl, 1'b0);
        chk("mid_rst_wvalid", bmain_wvalid_dctl, 1'b0);
        chk("mid_rst_rready", bmain_rready_dctl, 1'b0);
        chk("mid_rst_resp_valid", resp_valid, 1'b0);
        reset = 1'b0;
        tick();
        write_best(24'h00_0030, {32'hCAFE0004, 32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001},
                   16'h1234, "wr4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
